// File: rtl/rsa_pkg.sv
// rsa_pkg: shared state encoding and default sizing for the RSA request arbiter.
package rsa_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 1 << 20;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first set request at or after ptr.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        // Scanning from the far end lets the nearest candidate overwrite the rest.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[IW'((int'(ptr_i) + k) % NUM_REQ)]) begin
                idx_o = IW'((int'(ptr_i) + k) % NUM_REQ);
                any_o = 1'b1;
            end
        end
        grant_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/rsa_req_arbiter.sv
// rsa_req_arbiter: round-robin sequencer sharing one RSA engine among NUM_REQ requesters,
// with operand screening and a watchdog on the engine handshake.
module rsa_req_arbiter
    import rsa_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*2*WIDTH-1:0] req_m,
    input  logic [NUM_REQ*WIDTH-1:0]   req_e,
    input  logic [NUM_REQ*2*WIDTH-1:0] req_n,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]         rsp_c,
    output logic                       rsp_err,
    output logic                       busy,
    output logic                       eng_start,
    output logic [2*WIDTH-1:0]         eng_m,
    output logic [WIDTH-1:0]           eng_e,
    output logic [2*WIDTH-1:0]         eng_n,
    input  logic [2*WIDTH-1:0]         eng_c,
    input  logic                       eng_finish
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam int MW = 2 * WIDTH;

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d, g_q, g_d;
    logic [NUM_REQ-1:0]   gh_q, gh_d;
    logic [MW-1:0]        m_q, m_d, n_q, n_d, c_q, c_d;
    logic [WIDTH-1:0]     e_q, e_d;
    logic                 err_q, err_d;
    logic [WW-1:0]        wd_q, wd_d;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 legal;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign legal = (|e_q) && (|n_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        gh_d    = gh_q;
        m_d     = m_q;
        e_d     = e_q;
        n_d     = n_q;
        c_d     = c_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: if (pick_any) begin
                g_d     = pick_idx;
                gh_d    = pick_grant;
                m_d     = req_m[pick_idx*MW +: MW];
                e_d     = req_e[pick_idx*WIDTH +: WIDTH];
                n_d     = req_n[pick_idx*MW +: MW];
                state_d = ISSUE;
            end
            ISSUE: begin
                wd_d    = '0;
                err_d   = !legal;
                c_d     = '0;
                state_d = legal ? WAIT : RESP;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                // A finish in the expiry cycle still delivers the real result.
                if (eng_finish) begin
                    c_d     = eng_c;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    c_d     = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            gh_q    <= '0;
            m_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            gh_q    <= gh_d;
            m_q     <= m_d;
            e_q     <= e_d;
            n_q     <= n_d;
            c_q     <= c_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign req_ready = (state_q == ISSUE) ? gh_q : '0;
    assign rsp_valid = (state_q == RESP) ? gh_q : '0;
    assign rsp_c     = (state_q == RESP) ? c_q : '0;
    assign rsp_err   = (state_q == RESP) && err_q;
    assign busy      = state_q != IDLE;
    assign eng_start = (state_q == ISSUE) && legal;
    assign eng_m     = m_q;
    assign eng_e     = e_q;
    assign eng_n     = n_q;
endmodule

// File: tb/tb_rsa_req_arbiter.sv
// tb_rsa_req_arbiter: vector table, directed corner sequences and randomized traffic
// checked against a round-robin / modular-exponentiation reference model.
module tb_rsa_req_arbiter;
    localparam int W = 8, N = 4, TO = 64;

    typedef struct {
        int          r;
        logic [15:0] m;
        logic [7:0]  e;
        logic [15:0] n;
        int          lat;
        logic [15:0] c;
        logic        err;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] req_valid, req_ready, rsp_valid;
    logic [N*2*W-1:0] req_m, req_n;
    logic [N*W-1:0] req_e;
    logic [2*W-1:0] rsp_c, eng_m, eng_n, eng_c;
    logic [W-1:0] eng_e;
    logic rsp_err, busy, eng_start, eng_finish;
    int n_vec = 0, n_bad = 0, starts = 0, lat = 1, ptr_m = 0;
    bit eng_dead = 1'b0;
    logic [15:0] eng_r;
    vec_t tv[6];

    always #5 clk = ~clk;

    rsa_req_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_m(req_m), .req_e(req_e),
        .req_n(req_n), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_c(rsp_c),
        .rsp_err(rsp_err), .busy(busy), .eng_start(eng_start), .eng_m(eng_m),
        .eng_e(eng_e), .eng_n(eng_n), .eng_c(eng_c), .eng_finish(eng_finish)
    );

    function automatic logic [15:0] modexp(input logic [15:0] m, input logic [7:0] e, input logic [15:0] n);
        longint r;
        if (n == 0) return 16'd0;
        r = 1 % longint'(n);
        for (int i = 0; i < int'(e); i++) r = (r * longint'(m)) % longint'(n);
        return 16'(r);
    endfunction

    always @(posedge clk) if (eng_start) starts <= starts + 1;

    // Engine stub: answers lat cycles after the start pulse unless eng_dead.
    initial begin
        eng_finish = 1'b0;
        eng_c = '0;
        forever begin
            @(posedge clk);
            if (eng_start && !eng_dead) begin
                eng_r = modexp(eng_m, eng_e, eng_n);
                repeat (lat - 1) @(posedge clk);
                #1 eng_finish = 1'b1;
                eng_c = eng_r;
                @(posedge clk);
                #1 eng_finish = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [15:0] m, input logic [7:0] e, input logic [15:0] n);
        req_m[r*16 +: 16] = m;
        req_e[r*8 +: 8]   = e;
        req_n[r*16 +: 16] = n;
    endtask

    // Called at a sample point inside an IDLE cycle with the request already driven.
    task automatic serve_one(input logic [3:0] eg, input logic [15:0] ec, input logic ee,
                             input int dly, input int es, input logic nv, input string tag);
        int k, s0;
        s0 = starts;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (req_ready == '0 && k < 4);
        chk({tag, ".ready"}, 64'(req_ready), 64'(eg));
        chk({tag, ".ready_dly"}, 64'(k), 64'd1);
        if (req_ready == '0) return;
        req_valid = nv ? req_valid : (req_valid & ~req_ready);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (rsp_valid == '0 && k < TO + 8);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(eg));
        chk({tag, ".rsp_c"}, 64'(rsp_c), 64'(ec));
        chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(ee));
        chk({tag, ".rsp_dly"}, 64'(k), 64'(dly));
        chk({tag, ".starts"}, 64'(starts - s0), 64'(es));
    endtask

    initial begin
        logic [3:0] v;
        logic [15:0] m, n;
        logic [7:0] e;
        logic err;
        logic seen;
        int g;
        tv[0] = '{1, 16'd5, 8'd3, 16'd33, 3, 16'd26, 1'b0};
        tv[1] = '{2, 16'd4, 8'd13, 16'd497, 5, 16'd445, 1'b0};
        tv[2] = '{0, 16'd9, 8'd0, 16'd77, 2, 16'd0, 1'b1};
        tv[3] = '{3, 16'd9, 8'd7, 16'd0, 2, 16'd0, 1'b1};
        tv[4] = '{3, 16'd2, 8'd10, 16'd1000, 1, 16'd24, 1'b0};
        tv[5] = '{0, 16'h1234, 8'd1, 16'h8000, 4, 16'h1234, 1'b0};
        req_valid = '0; req_m = '0; req_e = '0; req_n = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 64'(busy), 0);
        chk("rst.ready", 64'(req_ready), 0);
        chk("rst.rsp", 64'(rsp_valid), 0);
        chk("rst.eng_start", 64'(eng_start), 0);
        chk("rst.eng_ops", {eng_m, eng_e, eng_n}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            lat = tv[i].lat;
            set_req(tv[i].r, tv[i].m, tv[i].e, tv[i].n);
            req_valid = 4'(1 << tv[i].r);
            serve_one(4'(1 << tv[i].r), tv[i].c, tv[i].err, tv[i].err ? 1 : tv[i].lat + 1,
                      tv[i].err ? 0 : 1, 1'b0, $sformatf("vec%0d", i));
            @(posedge clk); #1;
        end

        eng_dead = 1'b1;
        set_req(1, 16'd7, 8'd5, 16'd91);
        req_valid = 4'b0010;
        serve_one(4'b0010, 16'd0, 1'b1, TO + 1, 1, 1'b0, "timeout");
        eng_dead = 1'b0;
        @(posedge clk); #1;
        eng_finish = 1'b1;
        eng_c = 16'hbeef;
        @(posedge clk); #1;
        eng_finish = 1'b0;
        chk("late.rsp", 64'(rsp_valid), 0);
        chk("late.busy", 64'(busy), 0);
        lat = 2;
        set_req(0, 16'd11, 8'd3, 16'd50);
        set_req(2, 16'd6, 8'd4, 16'd100);
        req_valid = 4'b0101;
        serve_one(4'b0100, modexp(16'd6, 8'd4, 16'd100), 1'b0, 3, 1, 1'b0, "after_to");
        @(posedge clk); #1;
        serve_one(4'b0001, modexp(16'd11, 8'd3, 16'd50), 1'b0, 3, 1, 1'b0, "after_to2");
        @(posedge clk); #1;

        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int r = 0; r < N; r++) set_req(r, 16'(r + 2), 8'(r + 3), 16'(100 + 7 * r));
        req_valid = 4'b1111;
        lat = 2;
        for (int j = 0; j < 5; j++) begin
            g = j % N;
            serve_one(4'(1 << g), modexp(16'(g + 2), 8'(g + 3), 16'(100 + 7 * g)), 1'b0, 3, 1, 1'b1,
                      $sformatf("fair%0d", j));
            @(posedge clk); #1;
        end
        req_valid = '0;

        set_req(2, 16'd3, 8'd5, 16'd40);
        req_valid = 4'b0100;
        serve_one(4'b0100, modexp(16'd3, 8'd5, 16'd40), 1'b0, 3, 1, 1'b0, "pre_abort");
        @(posedge clk); #1;
        lat = 20;
        req_valid = 4'b0100;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort.busy", 64'(busy), 0);
        chk("abort.eng_start", 64'(eng_start), 0);
        chk("abort.outs", {req_ready, rsp_valid, rsp_c, 7'd0, rsp_err}, 0);
        chk("abort.eng_ops", {eng_m, eng_e, eng_n}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin @(posedge clk); #1; seen = seen | (|rsp_valid); end
        chk("abort.no_rsp", 64'(seen), 0);
        lat = 1;
        set_req(0, 16'd8, 8'd2, 16'd60);
        set_req(3, 16'd9, 8'd2, 16'd60);
        req_valid = 4'b1001;
        serve_one(4'b0001, modexp(16'd8, 8'd2, 16'd60), 1'b0, 2, 1, 1'b0, "ptr_reset");
        @(posedge clk); #1;
        ptr_m = 1;

        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < N; r++) begin
                m = 16'($urandom);
                e = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                n = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
                set_req(r, m, e, n);
            end
            v = 4'($urandom_range(1, 15));
            req_valid = v;
            lat = $urandom_range(1, 4);
            g = -1;
            for (int k = 0; k < N; k++) if (g < 0 && v[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            m = req_m[g*16 +: 16];
            e = req_e[g*8 +: 8];
            n = req_n[g*16 +: 16];
            err = (e == 0) || (n == 0);
            serve_one(4'(1 << g), err ? 16'd0 : modexp(m, e, n), err, err ? 1 : lat + 1,
                      err ? 0 : 1, 1'($urandom_range(0, 1)), $sformatf("rand%0d", it));
            ptr_m = (g + 1) % N;
            @(posedge clk); #1;
        end
        req_valid = '0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
